// File: rtl/gates7_bist.sv
// ---------------------------------------------------------------------------
// gates7_bist
//
// Hardware stimulus/response engine for the seven-function gate unit
// (and, or, not, nand, nor, xor, xnor). It drives the operands a/b through
// the four input combinations, samples the unit's seven results, and checks
// them against locally computed expected values. It reports pass/fail, a
// saturating error count, and the first failing vector.
//
// Parameters
//   SETTLE  idle cycles between driving a vector and sampling f (0..15)
//   PASSES  number of full 4-vector sweeps per run (1..255)
//   ERRW    width of the error counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   run request, only honoured in IDLE or DONE
//   a, b       out  registered operands to the gate unit
//   f[6:0]     in   gate unit results {and,or,not,nand,nor,xor,xnor}
//   busy       out  high while a run is in progress
//   done       out  high once a run completes, held until next start/reset
//   pass       out  high with done when no vector mismatched
//   err_cnt    out  saturating count of mismatching vectors
//   fail_vec   out  {b,a} of the first failing vector of the run
//   fail_mask  out  f XOR expected at the first failing vector
// ---------------------------------------------------------------------------
module gates7_bist #(
    parameter int SETTLE = 1,
    parameter int PASSES = 1,
    parameter int ERRW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            a,
    output logic            b,
    input  logic [6:0]      f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [1:0]      fail_vec,
    output logic [6:0]      fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Terminal values for the settle and pass counters. With SETTLE=0 the
    // settle state is never entered, so its terminal value is irrelevant.
    localparam logic [3:0]      SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [7:0]      PASS_LAST   = 8'(PASSES - 1);
    localparam logic [ERRW-1:0] ERR_MAX     = '1;
    localparam logic [ERRW-1:0] ERR_ONE     = ERRW'(1);

    // State after a vector is driven: skip the settle state entirely when no
    // settle time is requested.
    localparam state_t AFTER_DRIVE = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t          state_q,      state_d;
    logic [1:0]      v_q,          v_d;
    logic [7:0]      pass_cnt_q,   pass_cnt_d;
    logic [3:0]      settle_cnt_q, settle_cnt_d;
    logic            a_q,          a_d;
    logic            b_q,          b_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;
    logic            pass_q,       pass_d;
    logic [ERRW-1:0] err_cnt_q,    err_cnt_d;
    logic [1:0]      fail_vec_q,   fail_vec_d;
    logic [6:0]      fail_mask_q,  fail_mask_d;

    logic [6:0]      expected;
    logic [6:0]      mask;
    logic [1:0]      next_v;
    logic            last_vector;

    // Reference gate results from the operands currently on the bus, packed
    // in the same order as f so the two can be XORed bit for bit.
    always_comb begin
        expected = {a_q & b_q,
                    a_q | b_q,
                    ~a_q,
                    ~(a_q & b_q),
                    ~(a_q | b_q),
                    a_q ^ b_q,
                    ~(a_q ^ b_q)};
        mask        = f ^ expected;
        next_v      = v_q + 2'd1;
        last_vector = (v_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    end

    // Next-state and next-output logic. All outputs are registered, so every
    // output change is decided here one edge ahead.
    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        pass_cnt_d   = pass_cnt_q;
        settle_cnt_d = settle_cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_mask_d  = fail_mask_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A new run wipes every result of the previous one at the
                // start edge and drives vector 0 immediately.
                if (start) begin
                    state_d      = AFTER_DRIVE;
                    v_d          = 2'd0;
                    pass_cnt_d   = 8'd0;
                    settle_cnt_d = 4'd0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_vec_d   = 2'd0;
                    fail_mask_d  = 7'd0;
                end
            end

            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = 4'd0;
                    state_d      = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end

            S_CHECK: begin
                // The error count itself marks whether this is the first
                // error of the run: it only leaves zero on a mismatch and
                // saturates instead of wrapping.
                if (mask != 7'd0) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                    end
                    if (err_cnt_q == '0) begin
                        fail_vec_d  = {b_q, a_q};
                        fail_mask_d = mask;
                    end
                end

                if (last_vector) begin
                    // pass looks at the count including this final check.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = AFTER_DRIVE;
                    v_d     = next_v;
                    a_d     = next_v[0];
                    b_d     = next_v[1];
                    if (v_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once so an
    // aborted run leaves no partial results behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            v_q          <= 2'd0;
            pass_cnt_q   <= 8'd0;
            settle_cnt_q <= 4'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= 2'd0;
            fail_mask_q  <= 7'd0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            pass_cnt_q   <= pass_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            fail_mask_q  <= fail_mask_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gates7_bist.sv
// ---------------------------------------------------------------------------
// tb_gates7_bist
//
// Bench for gates7_bist. Two instances share clock and reset:
//   dut0  SETTLE=1, PASSES=1, ERRW=4
//   dut1  SETTLE=1, PASSES=2, ERRW=2
// Each instance is attached to a behavioural gate unit whose fault can be
// selected (correct, xor stuck at 0, all outputs inverted). Expected run
// results are queued when a run is started and compared by a monitor when
// done rises.
// ---------------------------------------------------------------------------
module tb_gates7_bist;

    logic       clk;
    logic       rst;
    logic       start0, start1;
    logic       a0, b0, a1, b1;
    logic [6:0] f0, f1;
    logic       busy0, done0, pass0;
    logic       busy1, done1, pass1;
    logic [3:0] err_cnt0;
    logic [1:0] err_cnt1;
    logic [1:0] fail_vec0, fail_vec1;
    logic [6:0] fail_mask0, fail_mask1;

    int mode0;
    int mode1;
    int cycle;
    int tests_run;
    int tests_failed;

    typedef struct {
        int         done_cycle;
        logic [3:0] err;
        logic       pass;
        logic [1:0] fv;
        logic [6:0] fm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic done0_prev;
    logic done1_prev;

    // {b,a} expected on the operand bus at each negedge after the start
    // edge for SETTLE=1: each vector is held for two cycles.
    logic [1:0] exp_ab [8];

    gates7_bist #(.SETTLE(1), .PASSES(1), .ERRW(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .f(f0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err_cnt0), .fail_vec(fail_vec0), .fail_mask(fail_mask0)
    );

    gates7_bist #(.SETTLE(1), .PASSES(2), .ERRW(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err_cnt1), .fail_vec(fail_vec1), .fail_mask(fail_mask1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural gate unit with optional faults:
    // 0 = correct, 1 = xor output stuck at 0, 2 = every output inverted.
    function automatic logic [6:0] gateUnit(input logic a, input logic b, input int mode);
        logic [6:0] r;
        r = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        if (mode == 1) r[1] = 1'b0;
        if (mode == 2) r = ~r;
        return r;
    endfunction

    always_comb f0 = gateUnit(a0, b0, mode0);
    always_comb f1 = gateUnit(a1, b1, mode1);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Queue the expected result (when a run should complete) and pulse start
    // for one edge. Returns at the negedge following the start edge.
    task automatic applyStimulus(input int which, input bit expect_done,
                                 input logic [3:0] err, input logic pass,
                                 input logic [1:0] fv, input logic [6:0] fm);
        exp_t e;
        @(negedge clk);
        e.done_cycle = cycle + 1 + ((which == 0) ? 8 : 16);
        e.err  = err;
        e.pass = pass;
        e.fv   = fv;
        e.fm   = fm;
        if (expect_done) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        if (which == 0) start0 = 1'b1;
        else            start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitDone(input int which, input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && !((which == 0) ? done0 : done1)) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!((which == 0) ? done0 : done1)) begin
            tests_failed++;
            $display("[TB] FAIL done timeout dut%0d: got done=0, expected done=1 within %0d cycles", which, max_cycles);
        end
        @(negedge clk);
    endtask

    task automatic checkReset0();
        checkOutput("rst a",         {31'd0, a0},         32'd0);
        checkOutput("rst b",         {31'd0, b0},         32'd0);
        checkOutput("rst busy",      {31'd0, busy0},      32'd0);
        checkOutput("rst done",      {31'd0, done0},      32'd0);
        checkOutput("rst pass",      {31'd0, pass0},      32'd0);
        checkOutput("rst err_cnt",   {28'd0, err_cnt0},   32'd0);
        checkOutput("rst fail_vec",  {30'd0, fail_vec0},  32'd0);
        checkOutput("rst fail_mask", {25'd0, fail_mask0}, 32'd0);
    endtask

    // Monitor: on each rising done, pop the oldest expectation for that
    // instance and compare timing and all result fields.
    always @(negedge clk) begin
        exp_t e;
        if (done0 && !done0_prev) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                checkOutput("dut0 done cycle", cycle,               e.done_cycle);
                checkOutput("dut0 busy",       {31'd0, busy0},      32'd0);
                checkOutput("dut0 err_cnt",    {28'd0, err_cnt0},   {28'd0, e.err});
                checkOutput("dut0 pass",       {31'd0, pass0},      {31'd0, e.pass});
                checkOutput("dut0 fail_vec",   {30'd0, fail_vec0},  {30'd0, e.fv});
                checkOutput("dut0 fail_mask",  {25'd0, fail_mask0}, {25'd0, e.fm});
            end
        end
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("dut1 done cycle", cycle,               e.done_cycle);
                checkOutput("dut1 busy",       {31'd0, busy1},      32'd0);
                checkOutput("dut1 err_cnt",    {30'd0, err_cnt1},   {28'd0, e.err});
                checkOutput("dut1 pass",       {31'd0, pass1},      {31'd0, e.pass});
                checkOutput("dut1 fail_vec",   {30'd0, fail_vec1},  {30'd0, e.fv});
                checkOutput("dut1 fail_mask",  {25'd0, fail_mask1}, {25'd0, e.fm});
            end
        end
        done0_prev <= done0;
        done1_prev <= done1;
    end

    initial begin
        exp_ab = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        cycle        = 0;
        tests_run    = 0;
        tests_failed = 0;
        mode0  = 0;
        mode1  = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        checkReset0();
        checkOutput("rst dut1 err_cnt", {30'd0, err_cnt1}, 32'd0);
        checkOutput("rst dut1 done",    {31'd0, done1},    32'd0);
        rst = 1'b0;

        // Correct unit: operand stepping and clean pass.
        $display("[TB] correct sweep");
        mode0 = 0;
        applyStimulus(0, 1'b1, 4'd0, 1'b1, 2'd0, 7'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("step%0d ab", k), {30'd0, b0, a0}, {30'd0, exp_ab[k]});
            checkOutput($sformatf("step%0d busy", k), {31'd0, busy0}, 32'd1);
            if (k < 7) @(negedge clk);
        end
        waitDone(0, 20);

        // xor stuck at 0: mismatches at (1,0) and (0,1).
        $display("[TB] xor stuck-at-0");
        mode0 = 1;
        applyStimulus(0, 1'b1, 4'd2, 1'b0, 2'b01, 7'b0000010);
        waitDone(0, 20);

        // Restart from DONE with errors latched: results clear at start edge.
        $display("[TB] restart clears results");
        mode0 = 0;
        applyStimulus(0, 1'b1, 4'd0, 1'b1, 2'd0, 7'd0);
        checkOutput("restart done",      {31'd0, done0},      32'd0);
        checkOutput("restart pass",      {31'd0, pass0},      32'd0);
        checkOutput("restart err_cnt",   {28'd0, err_cnt0},   32'd0);
        checkOutput("restart fail_vec",  {30'd0, fail_vec0},  32'd0);
        checkOutput("restart fail_mask", {25'd0, fail_mask0}, 32'd0);
        waitDone(0, 20);

        // start pulsed while busy is ignored; done timing is unchanged.
        $display("[TB] start while busy");
        mode0 = 1;
        applyStimulus(0, 1'b1, 4'd2, 1'b0, 2'b01, 7'b0000010);
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitDone(0, 20);

        // Reset during the CHECK cycle of vector 2, then a clean full sweep.
        $display("[TB] reset mid-run");
        mode0 = 0;
        applyStimulus(0, 1'b0, 4'd0, 1'b0, 2'd0, 7'd0);
        repeat (5) @(negedge clk);
        checkOutput("pre-reset ab", {30'd0, b0, a0}, 32'd2);
        rst = 1'b1;
        #1;
        checkReset0();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 4'd0, 1'b1, 2'd0, 7'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rerun step%0d ab", k), {30'd0, b0, a0}, {30'd0, exp_ab[k]});
            if (k < 7) @(negedge clk);
        end
        waitDone(0, 20);

        // ERRW=2, PASSES=2, all outputs inverted: 8 failures saturate at 3.
        $display("[TB] saturating error count");
        mode1 = 2;
        applyStimulus(1, 1'b1, 4'd3, 1'b0, 2'b00, 7'b1111111);
        waitDone(1, 40);

        checkOutput("dut0 queue empty", q0.size(), 32'd0);
        checkOutput("dut1 queue empty", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
